// File: rtl/uctl_bank_pkg.sv
// Shared definitions for the single-bank responder: port ids, read tag layout
// and the supported SRAM read-latency ceiling.
package uctl_bank_pkg;

    localparam int unsigned RD_LAT_MAX = 4;

    typedef enum logic {
        PORT_BUS = 1'b0,
        PORT_DMA = 1'b1
    } port_e;

    typedef struct packed {
        logic  valid;
        port_e port;
    } rd_tag_t;

endpackage

// File: rtl/uctl_bank_rd_pipe.sv
// Read-tag shift register; o_tag lines up with the cycle in which the SRAM
// read data for that tag is present on sram_rData.
module uctl_bank_rd_pipe
    import uctl_bank_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  rd_tag_t i_tag,
    output rd_tag_t o_tag
);

    localparam int unsigned DEPTH = RD_LAT + 1;

    rd_tag_t [DEPTH-1:0] r_stage;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[DEPTH-2:0], i_tag};
        end
    end

    assign o_tag = r_stage[RD_LAT];

endmodule

// File: rtl/uctl_bank_resp.sv
// Single-bank responder: round-robin arbitration between bus and DMA ports onto
// one single-port SRAM, with in-order read-data return per port.
module uctl_bank_resp
    import uctl_bank_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                  uctl_clk,
    input  logic                  uctl_rst_n,
    input  logic                  uctl_bankReq,
    input  logic                  uctl_bankWr,
    input  logic [ADDR_W-1:0]     uctl_bankAddr,
    input  logic [DATA_W-1:0]     uctl_bankWrData,
    input  logic [DATA_W/8-1:0]   uctl_bankByteEn,
    output logic                  uctl_bankAck,
    output logic                  uctl_bankDVl,
    output logic [DATA_W-1:0]     uctl_bankRdData,
    input  logic                  dma_req,
    input  logic                  dma_wr,
    input  logic [ADDR_W-1:0]     dma_addr,
    input  logic [DATA_W-1:0]     dma_wrData,
    input  logic [DATA_W/8-1:0]   dma_byteEn,
    output logic                  dma_ack,
    output logic                  dma_dVl,
    output logic [DATA_W-1:0]     dma_rdData,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W/8-1:0]   sram_be,
    output logic [DATA_W-1:0]     sram_wData,
    input  logic [DATA_W-1:0]     sram_rData
);

    localparam int unsigned BE_W = DATA_W / 8;

    port_e              r_ptr;
    logic               r_busAck;
    logic               r_dmaAck;
    logic               r_cs;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [BE_W-1:0]    r_be;
    logic [DATA_W-1:0]  r_wData;
    logic               r_busDVl;
    logic               r_dmaDVl;
    logic [DATA_W-1:0]  r_busRdData;
    logic [DATA_W-1:0]  r_dmaRdData;

    logic               w_busElig;
    logic               w_dmaElig;
    logic               w_grantBus;
    logic               w_grantDma;
    logic               w_grant;
    logic               w_selWr;
    logic [ADDR_W-1:0]  w_selAddr;
    logic [DATA_W-1:0]  w_selWData;
    logic [BE_W-1:0]    w_selBe;
    rd_tag_t            w_tagIn;
    rd_tag_t            w_tagOut;

    // A port whose ack is showing this cycle is still dropping req; ignore it.
    assign w_busElig  = uctl_bankReq & ~r_busAck;
    assign w_dmaElig  = dma_req & ~r_dmaAck;
    assign w_grantBus = w_busElig & (~w_dmaElig | (r_ptr == PORT_BUS));
    assign w_grantDma = w_dmaElig & (~w_busElig | (r_ptr == PORT_DMA));
    assign w_grant    = w_grantBus | w_grantDma;

    always_comb begin
        w_selWr    = uctl_bankWr;
        w_selAddr  = uctl_bankAddr;
        w_selWData = uctl_bankWrData;
        w_selBe    = uctl_bankByteEn;
        if (w_grantDma) begin
            w_selWr    = dma_wr;
            w_selAddr  = dma_addr;
            w_selWData = dma_wrData;
            w_selBe    = dma_byteEn;
        end
        w_tagIn.valid = w_grant & ~w_selWr;
        w_tagIn.port  = w_grantDma ? PORT_DMA : PORT_BUS;
    end

    always_ff @(posedge uctl_clk or negedge uctl_rst_n) begin
        if (!uctl_rst_n) begin
            r_ptr    <= PORT_BUS;
            r_busAck <= 1'b0;
            r_dmaAck <= 1'b0;
            r_cs     <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_be     <= '0;
            r_wData  <= '0;
        end else begin
            r_busAck <= w_grantBus;
            r_dmaAck <= w_grantDma;
            r_cs     <= w_grant;
            r_we     <= w_grant & w_selWr;
            if (w_grant) begin
                r_ptr   <= w_grantBus ? PORT_DMA : PORT_BUS;
                r_addr  <= w_selAddr;
                r_be    <= w_selWr ? w_selBe : '1;
                r_wData <= w_selWData;
            end
        end
    end

    uctl_bank_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .i_clk   (uctl_clk),
        .i_rst_n (uctl_rst_n),
        .i_tag   (w_tagIn),
        .o_tag   (w_tagOut)
    );

    always_ff @(posedge uctl_clk or negedge uctl_rst_n) begin
        if (!uctl_rst_n) begin
            r_busDVl    <= 1'b0;
            r_dmaDVl    <= 1'b0;
            r_busRdData <= '0;
            r_dmaRdData <= '0;
        end else begin
            r_busDVl <= w_tagOut.valid & (w_tagOut.port == PORT_BUS);
            r_dmaDVl <= w_tagOut.valid & (w_tagOut.port == PORT_DMA);
            if (w_tagOut.valid && (w_tagOut.port == PORT_BUS)) begin
                r_busRdData <= sram_rData;
            end
            if (w_tagOut.valid && (w_tagOut.port == PORT_DMA)) begin
                r_dmaRdData <= sram_rData;
            end
        end
    end

    assign uctl_bankAck    = r_busAck;
    assign uctl_bankDVl    = r_busDVl;
    assign uctl_bankRdData = r_busRdData;
    assign dma_ack         = r_dmaAck;
    assign dma_dVl         = r_dmaDVl;
    assign dma_rdData      = r_dmaRdData;
    assign sram_cs         = r_cs;
    assign sram_we         = r_we;
    assign sram_addr       = r_addr;
    assign sram_be         = r_be;
    assign sram_wData      = r_wData;

endmodule

// File: doc/uctl_bank_resp.md
# uctl_bank_resp

Single-bank responder sitting behind the controller's bank-select fan-out. It turns one bank request line from the bus side, plus a second request port from the packet DMA engine, into accesses on one single-port SRAM macro. It returns a one-cycle acknowledge per accepted access and an in-order read-data-valid pulse with data. Four instances, one per bank, sit behind the bank select; their ack/valid outputs are ORed there.

## Interface
- ADDR_W, 10, bank word address width
- DATA_W, 32, data width; multiple of 8
- RD_LAT, 1, SRAM read latency in cycles from sram_cs to sram_rData valid; legal 1..4
- uctl_clk  in  1  block clock; all logic on rising edge
- uctl_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- uctl_bankReq  in  1  bus request; held high until uctl_bankAck is seen
- uctl_bankWr  in  1  1 = write, 0 = read; qualified by uctl_bankReq
- uctl_bankAddr  in  ADDR_W  bus word address
- uctl_bankWrData  in  DATA_W  bus write data
- uctl_bankByteEn  in  DATA_W/8  bus write byte enables
- uctl_bankAck  out  1  one-cycle pulse; bus access accepted and issued
- uctl_bankDVl  out  1  one-cycle pulse; uctl_bankRdData valid
- uctl_bankRdData  out  DATA_W  bus read data
- dma_req, dma_wr, dma_addr, dma_wrData, dma_byteEn  in  1/1/ADDR_W/DATA_W/DATA_W/8  DMA port; same meaning as the bus port
- dma_ack, dma_dVl  out  1  DMA ack / read-valid pulses
- dma_rdData  out  DATA_W  DMA read data
- sram_cs, sram_we  out  1  SRAM chip select, write enable
- sram_addr  out  ADDR_W  SRAM address
- sram_be  out  DATA_W/8  SRAM byte enables
- sram_wData  out  DATA_W  SRAM write data
- sram_rData  in  DATA_W  SRAM read data; valid RD_LAT cycles after the sram_cs cycle

## Operation
- Eligible port: request high and its ack not high in the current cycle. This masks the cycle in which the requester is still dropping req.
- Arbitration is round-robin with a one-bit priority pointer. Reset value: bus.
- One eligible port: that port is granted.
- Both ports eligible: the pointer's port is granted. The pointer then moves to the other port.
- A grant with no contention also moves the pointer to the other port.
- Grant in cycle t: all sram_* outputs and the port ack are registered and valid in cycle t+1. sram_cs is high for exactly that cycle. sram_be is all-ones for reads.
- Writes: ack only. No dVl pulse is produced.
- Reads: a tag {valid, port} enters a RD_LAT+1 deep shift pipe at t+1. sram_rData is captured at t+1+RD_LAT. The selected port's rdData register loads and its dVl pulses at t+2+RD_LAT.
- Reads complete in issue order. No limit on outstanding reads; the pipe depth covers every in-flight read.
- rdData registers hold their last value when dVl is low.
- Max throughput:
  - one SRAM access per cycle when both ports alternate;
  - one access every 2 cycles for a single port, because of the ack mask.

## Timing
- Reset values: all outputs 0; rdData registers 0; tag pipe cleared; pointer = bus.
- Reset asserted mid-operation: in-flight reads are discarded. No ack or dVl pulse appears after reset release for requests issued before reset.
- Read latency from the req-high cycle, idle block: ack at +1, dVl at +2+RD_LAT. With RD_LAT=1, dVl arrives at +3.
- Simultaneous bus read and DMA write at reset:
  - bus granted first: bus ack at +1;
  - DMA granted next: DMA ack at +2.
- Dropping req without seeing ack is illegal. Behaviour is undefined; the bench flags it as an error.

## Structure
- Shared package uctl_bank_pkg holds:
  - port-id constants (PORT_BUS=0, PORT_DMA=1);
  - the read-tag struct {valid, port};
  - RD_LAT_MAX=4.
- Sub-module uctl_bank_rd_pipe: parameterised tag shift register (depth RD_LAT+1). Outputs the tag aligned with the sram_rData capture point. Async active-low clear.
- Top level holds the arbiter, the SRAM output registers and the two rdData registers.

## Test plan
- Bus read, RD_LAT=1: addr 0x005 preloaded with 0xDEADBEEF; req at cycle 0 -> ack at 1, sram_cs/addr 0x005 at 1, uctl_bankDVl with 0xDEADBEEF at 3.
- Bus write: 0x12345678 to 0x010 with byteEn 4'b0011 -> SRAM word old 0xAAAAAAAA becomes 0xAAAA5678. Ack only, no dVl.
- Contention: both ports request reads continuously from reset -> grants alternate bus, DMA, bus, …; sram_cs high every cycle; each port gets dVl every second cycle with the correct data.
- RD_LAT=4: DMA reads back-to-back at 0x000..0x003 -> four dma_dVl pulses, in order, each 6 cycles after its req-high cycle.
- Reset mid-flight: assert uctl_rst_n low one cycle after a read ack -> all outputs 0 during reset; no dVl after release; pointer back to bus.
- Ack mask: single port holds req one cycle too long, then drops -> exactly one ack and one SRAM access.
